// File: rtl/wb_dma_pkg.sv
// Shared types and widths for the Wishbone block-copy engine.
package wb_dma_pkg;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef enum logic [2:0] {IDLE, RD, GAP_W, WR, GAP_R, FIN} dma_state_t;
endpackage

// File: rtl/if_wb.sv
// Wishbone B4 pipelined bus bundle (16-bit address and data).
interface if_wb import wb_dma_pkg::*; ();
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          cyc;
  logic          stb;
  logic          we;
  logic          stall;
  logic          ack;

  modport master (output adr, dat_o, cyc, stb, we, input dat_i, stall, ack);
  modport slave  (input adr, dat_o, cyc, stb, we, output dat_i, stall, ack);
endinterface

// File: rtl/wb_dma_fifo.sv
// Chunk buffer: synchronous show-ahead FIFO holding one chunk of read data.
module wb_dma_fifo import wb_dma_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; clear returns the buffer to empty.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Chunk length never exceeds the depth, so a push into a full buffer is a design bug.
  always_ff @(posedge clk) begin
    if (!clr) assert (!(push && full));
  end
endmodule

// File: rtl/wb_dma.sv
// Wishbone pipelined block-copy initiator: reads a chunk into the FIFO, then writes it out.
module wb_dma import wb_dma_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_adr,
  input  logic [AW-1:0] dst_adr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  if_wb.master          wb
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  dma_state_t    state;
  dma_state_t    state_nxt;
  cnt_t          n;
  cnt_t          issued;
  cnt_t          acked;
  logic [AW-1:0] rem;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW-1:0] fifo_dout;

  logic          issue;
  logic          last_ack;
  logic          chunk_end;

  // Words in the next chunk: whatever remains, capped at the FIFO depth.
  function automatic cnt_t chunk_size(input logic [AW-1:0] words);
    if (words >= AW'(FIFO_DEPTH)) return cnt_t'(FIFO_DEPTH);
    return cnt_t'(words);
  endfunction

  assign issue     = stb && !wb.stall;
  assign last_ack  = wb.ack && (acked == n - cnt_t'(1));
  assign chunk_end = (state == WR) && last_ack;

  assign wb.cyc   = cyc;
  assign wb.stb   = stb;
  assign wb.we    = we;
  assign wb.adr   = adr;
  assign wb.dat_o = dat_o;

  wb_dma_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wb.dat_i),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next state and bus outputs; outputs depend only on registers so they hold under stall.
  always_comb begin
    state_nxt = state;
    cyc       = 1'b0;
    stb       = 1'b0;
    we        = 1'b0;
    adr       = '0;
    dat_o     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? FIN : RD;
      end
      RD: begin
        cyc       = 1'b1;
        busy      = 1'b1;
        stb       = (issued < n);
        adr       = src + AW'(issued);
        fifo_push = wb.ack && !fifo_full;
        if (last_ack) state_nxt = GAP_W;
      end
      GAP_W: begin
        busy      = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        cyc      = 1'b1;
        we       = 1'b1;
        busy     = 1'b1;
        stb      = (issued < n);
        adr      = dst + AW'(issued);
        dat_o    = fifo_dout;
        fifo_pop = stb && !wb.stall && !fifo_empty;
        if (last_ack) state_nxt = (rem == AW'(n)) ? FIN : GAP_R;
      end
      GAP_R: begin
        busy      = 1'b1;
        state_nxt = RD;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, per-phase counters, chunk size and remaining word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n      <= '0;
      issued <= '0;
      acked  <= '0;
      rem    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem    <= len;
            n      <= chunk_size(len);
            issued <= '0;
            acked  <= '0;
          end
        end
        RD, WR: begin
          if (issue)     issued <= issued + cnt_t'(1);
          if (wb.ack)    acked  <= acked + cnt_t'(1);
          if (chunk_end) rem    <= rem - AW'(n);
        end
        GAP_W: begin
          issued <= '0;
          acked  <= '0;
        end
        GAP_R: begin
          n      <= chunk_size(rem);
          issued <= '0;
          acked  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Address registers: latched on start, advanced by one chunk when its writes complete.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      src <= src_adr;
      dst <= dst_adr;
    end else if (chunk_end) begin
      src <= src + AW'(n);
      dst <= dst + AW'(n);
    end
  end
endmodule
